image_mem_arbiter: RTL and testbench

Shares the single-port 64x64 image memory between the VGA display path and a pixel writer (host/loader).
The display read has absolute priority whenever the timing generator asserts frame_imagem.
Writer requests are buffered in a small FIFO and drained into memory in cycles the display does not own.
The block sits between the hvsync timing generator, the image RAM and the pixel colour mux.

---
 rtl/image_mem_arbiter_if.sv | 25 ++
 rtl/image_mem_arbiter.sv | 122 ++++++++++++
 tb/tb_image_mem_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/image_mem_arbiter_if.sv
// Writer request and image RAM port signals shared by the arbiter and its neighbours.
// slave = arbiter side, master = writer/RAM side.
interface image_mem_arbiter_if #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 8
);
   logic              wr_valid;
   logic              wr_ready;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_we;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  wr_valid, wr_addr, wr_data, mem_rdata,
      output wr_ready, mem_addr, mem_we, mem_wdata
   );

   modport master (
      output wr_valid, wr_addr, wr_data, mem_rdata,
      input  wr_ready, mem_addr, mem_we, mem_wdata
   );
endinterface

// File: rtl/image_mem_arbiter.sv
// Single-port image RAM arbiter: display reads own the port while frame_imagem is high,
// queued writer requests drain otherwise. Optional WR_STALL_CNT_EN adds a stall_count output.
//
// state | meaning (what the RAM port does in the next cycle)
// IDLE  | no access; mem_addr/mem_wdata hold
// READ  | display read at rd_ptr
// WRITE | write of the FIFO head
module image_mem_arbiter #(
   parameter int ADDR_W     = 12,
   parameter int DATA_W     = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        frame_imagem,
   input  logic                        zerar,
   image_mem_arbiter_if.slave          bus,
   output logic [DATA_W-1:0]           pixel,
   output logic                        pixel_valid,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level
`ifdef WR_STALL_CNT_EN
   ,
   output logic [15:0]                 stall_count
`endif
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int LVL_W = PTR_W + 1;

   typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] rd_ptr;
   logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
   logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
   logic [PTR_W-1:0]  head, tail;
   logic              full, not_empty, push, pop;
   logic              rd_d2;

   // ready depends on the registered level only, so a pop never frees a slot in the same cycle
   assign full         = (fifo_level == LVL_W'(FIFO_DEPTH));
   assign not_empty    = (fifo_level != '0);
   assign bus.wr_ready = !full;
   assign push         = bus.wr_valid && !full;
   assign pop          = (state_d == WRITE);

   always_comb begin
      state_d = IDLE;
      if (frame_imagem)   state_d = READ;
      else if (not_empty) state_d = WRITE;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         bus.mem_addr  <= '0;
         bus.mem_we    <= 1'b0;
         bus.mem_wdata <= '0;
      end else begin
         state_q    <= state_d;
         bus.mem_we <= (state_d == WRITE);
         case (state_d)
            READ:  bus.mem_addr <= rd_ptr;
            WRITE: begin
               bus.mem_addr  <= fifo_addr[head];
               bus.mem_wdata <= fifo_data[head];
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset)             rd_ptr <= '0;
      else if (zerar)        rd_ptr <= '0;
      else if (frame_imagem) rd_ptr <= rd_ptr + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_addr[tail] <= bus.wr_addr;
         fifo_data[tail] <= bus.wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         head       <= '0;
         tail       <= '0;
         fifo_level <= '0;
      end else begin
         if (push) tail <= tail + PTR_W'(1);
         if (pop)  head <= head + PTR_W'(1);
         case ({push, pop})
            2'b10:   fifo_level <= fifo_level + LVL_W'(1);
            2'b01:   fifo_level <= fifo_level - LVL_W'(1);
            default: ;
         endcase
      end
   end

   // state_q == READ marks the cycle the address is on the RAM; data arrives one cycle later
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_d2       <= 1'b0;
         pixel_valid <= 1'b0;
         pixel       <= '0;
      end else begin
         rd_d2       <= (state_q == READ);
         pixel_valid <= rd_d2;
         if (rd_d2) pixel <= bus.mem_rdata;
      end
   end

`ifdef WR_STALL_CNT_EN
   always_ff @(posedge clk) begin
      if (reset)
         stall_count <= '0;
      else if (bus.wr_valid && !bus.wr_ready && stall_count != 16'hFFFF)
         stall_count <= stall_count + 16'd1;
   end
`endif
endmodule

// File: tb/tb_image_mem_arbiter.sv
// Directed bench for image_mem_arbiter with a behavioural synchronous RAM and a
// read-address/pixel-valid reference running alongside the stimulus.
module tb_image_mem_arbiter;
   localparam int ADDR_W     = 12;
   localparam int DATA_W     = 8;
   localparam int FIFO_DEPTH = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       frame_imagem = 1'b0;
   logic       zerar = 1'b0;
   logic [7:0] pixel;
   logic       pixel_valid;
   logic [2:0] fifo_level;
`ifdef WR_STALL_CNT_EN
   logic [15:0] stall_count;
`endif

   image_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   image_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
      .clk          (clk),
      .reset        (reset),
      .frame_imagem (frame_imagem),
      .zerar        (zerar),
      .bus          (bus),
      .pixel        (pixel),
      .pixel_valid  (pixel_valid),
      .fifo_level   (fifo_level)
`ifdef WR_STALL_CNT_EN
      ,
      .stall_count  (stall_count)
`endif
   );

   always #5 clk = ~clk;

   int n_tot = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tot++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // synchronous RAM, read-before-write
   logic [7:0] ram [4096];
   logic       preload = 1'b0;
   always @(posedge clk) begin
      if (preload) begin
         for (int i = 0; i < 4096; i++) ram[i] <= 8'(i);
      end else if (bus.mem_we) begin
         ram[bus.mem_addr] <= bus.mem_wdata;
      end
      bus.mem_rdata <= ram[bus.mem_addr];
   end

   // reference read pointer and display pipeline
   int          cyc = 0;
   logic        f_d1 = 1'b0, f_d2 = 1'b0, f_d3 = 1'b0;
   logic [11:0] m_ptr = '0, exp_addr = '0;
   logic        mon_en = 1'b0;
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (reset) begin
         m_ptr <= '0;
         f_d1  <= 1'b0;
         f_d2  <= 1'b0;
         f_d3  <= 1'b0;
      end else begin
         f_d1     <= frame_imagem;
         f_d2     <= f_d1;
         f_d3     <= f_d2;
         exp_addr <= m_ptr;
         if (zerar)             m_ptr <= '0;
         else if (frame_imagem) m_ptr <= m_ptr + 12'd1;
      end
   end

   typedef struct {
      logic [11:0] a;
      logic [7:0]  d;
      int          c;
   } wr_t;
   wr_t wlog[$];

   always @(negedge clk) begin
      if (mon_en) begin
         check("pixel_valid", pixel_valid, f_d3);
         if (f_d1) begin
            check("rd_addr", bus.mem_addr, exp_addr);
            check("we_in_read_slot", bus.mem_we, 1'b0);
         end
         if (bus.mem_we) wlog.push_back('{a: bus.mem_addr, d: bus.mem_wdata, c: cyc});
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [11:0] a, input logic [7:0] d, output int acc_cyc);
      logic r;
      logic ok;
      ok = 1'b0;
      acc_cyc = -1;
      bus.wr_valid = 1'b1;
      bus.wr_addr  = a;
      bus.wr_data  = d;
      for (int k = 0; k < 50 && !ok; k++) begin
         r = bus.wr_ready;
         tick();
         if (r) begin
            ok = 1'b1;
            acc_cyc = cyc;
         end
      end
      bus.wr_valid = 1'b0;
      check("push_timeout", ok, 1'b1);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int w0, a1, a2, a3, acc;
      logic r;
      logic [11:0] acc_a[$];
      logic [7:0]  acc_d[$];
      int n_push;

      bus.wr_valid = 1'b0;
      bus.wr_addr  = '0;
      bus.wr_data  = '0;
      preload = 1'b1;
      reset   = 1'b1;
      repeat (3) tick();
      preload = 1'b0;
      check("rst_mem_addr",  bus.mem_addr, 12'h000);
      check("rst_mem_we",    bus.mem_we, 1'b0);
      check("rst_mem_wdata", bus.mem_wdata, 8'h00);
      check("rst_pixel",     pixel, 8'h00);
      check("rst_pvalid",    pixel_valid, 1'b0);
      check("rst_level",     fifo_level, 3'd0);
      check("rst_ready",     bus.wr_ready, 1'b1);
`ifdef WR_STALL_CNT_EN
      check("rst_stall",     stall_count, 16'd0);
`endif
      reset  = 1'b0;
      mon_en = 1'b1;

      // 64-pixel display burst from the preloaded RAM
      w0 = wlog.size();
      frame_imagem = 1'b1;
      for (int k = 1; k <= 70; k++) begin
         tick();
         check("t1_pvalid", pixel_valid, (k >= 3 && k <= 66));
         if (k >= 3 && k <= 66) check("t1_pixel", pixel, 8'(k - 3));
         if (k == 64) frame_imagem = 1'b0;
      end
      check("t1_no_writes", wlog.size(), w0);

      // three back-to-back writes while the display is idle
      w0 = wlog.size();
      push(12'h010, 8'hAA, a1);
      check("t2_level1", fifo_level, 3'd1);
      push(12'h011, 8'hBB, a2);
      push(12'h010, 8'hCC, a3);
      repeat (4) tick();
      check("t2_nwrites", wlog.size() - w0, 3);
      if (wlog.size() - w0 == 3) begin
         check("t2_w0_addr", wlog[w0].a, 12'h010);
         check("t2_w0_data", wlog[w0].d, 8'hAA);
         check("t2_w0_cyc",  wlog[w0].c, a1 + 1);
         check("t2_w1_addr", wlog[w0+1].a, 12'h011);
         check("t2_w1_data", wlog[w0+1].d, 8'hBB);
         check("t2_w1_cyc",  wlog[w0+1].c, a1 + 2);
         check("t2_w2_addr", wlog[w0+2].a, 12'h010);
         check("t2_w2_data", wlog[w0+2].d, 8'hCC);
         check("t2_w2_cyc",  wlog[w0+2].c, a1 + 3);
      end
      check("t2_ram010", ram[12'h010], 8'hCC);
      check("t2_ram011", ram[12'h011], 8'hBB);
      check("t2_level0", fifo_level, 3'd0);

      // fill the FIFO while the display owns the port, then drain
      w0 = wlog.size();
      frame_imagem = 1'b1;
      for (int i = 0; i < 4; i++) push(12'h100 + 12'(i), 8'h50 + 8'(i), acc);
      check("t3_ready_full", bus.wr_ready, 1'b0);
      check("t3_level_full", fifo_level, 3'd4);
      bus.wr_valid = 1'b1;
      bus.wr_addr  = 12'h104;
      bus.wr_data  = 8'h54;
      for (int k = 0; k < 3; k++) begin
         tick();
         check("t3_blocked_ready", bus.wr_ready, 1'b0);
         check("t3_blocked_level", fifo_level, 3'd4);
      end
      bus.wr_valid = 1'b0;
`ifdef WR_STALL_CNT_EN
      check("t3_stall_count", stall_count, 16'd3);
`endif
      check("t3_no_writes", wlog.size(), w0);
      frame_imagem = 1'b0;
      tick();
      check("t3_ready_back", bus.wr_ready, 1'b1);
      check("t3_level3", fifo_level, 3'd3);
      check("t3_we", bus.mem_we, 1'b1);
      a1 = cyc;
      repeat (5) tick();
      check("t3_nwrites", wlog.size() - w0, 4);
      if (wlog.size() - w0 == 4) begin
         for (int i = 0; i < 4; i++) begin
            check("t3_addr", wlog[w0+i].a, 12'h100 + 12'(i));
            check("t3_data", wlog[w0+i].d, 8'h50 + 8'(i));
            check("t3_cyc",  wlog[w0+i].c, a1 + i);
         end
      end
      check("t3_level0", fifo_level, 3'd0);

      // saturated writer against an 8-on/2-off display pattern
      w0 = wlog.size();
      n_push = 0;
      for (int k = 0; k < 60; k++) begin
         frame_imagem = ((k % 10) < 8);
         bus.wr_valid = 1'b1;
         bus.wr_addr  = 12'h300 + 12'(n_push);
         bus.wr_data  = 8'(n_push) ^ 8'h5A;
         r = bus.wr_ready;
         tick();
         if (r) begin
            acc_a.push_back(12'h300 + 12'(n_push));
            acc_d.push_back(8'(n_push) ^ 8'h5A);
            n_push++;
         end
      end
      bus.wr_valid = 1'b0;
      frame_imagem = 1'b0;
      repeat (8) tick();
      check("t4_nwrites", wlog.size() - w0, acc_a.size());
      for (int i = 0; i < acc_a.size() && w0 + i < wlog.size(); i++) begin
         check("t4_addr", wlog[w0+i].a, acc_a[i]);
         check("t4_data", wlog[w0+i].d, acc_d[i]);
      end

      // read pointer wrap 4095 -> 0
      zerar = 1'b1;
      tick();
      zerar = 1'b0;
      frame_imagem = 1'b1;
      for (int k = 1; k <= 4097; k++) begin
         tick();
         if (k == 4096) check("t5_addr_4095", bus.mem_addr, 12'hFFF);
         if (k == 4097) check("t5_addr_wrap", bus.mem_addr, 12'h000);
      end

      // zerar clears the pointer, with and without a concurrent read
      frame_imagem = 1'b0;
      zerar = 1'b1;
      tick();
      zerar = 1'b0;
      frame_imagem = 1'b1;
      for (int k = 1; k <= 100; k++) begin
         tick();
         if (k == 1) check("t5_zerar_idle", bus.mem_addr, 12'h000);
      end
      zerar = 1'b1;
      tick();
      check("t5_addr_100", bus.mem_addr, 12'd100);
      zerar = 1'b0;
      tick();
      check("t5_zerar_read", bus.mem_addr, 12'h000);
      frame_imagem = 1'b0;
      repeat (4) tick();

      // reset with queued writes during a display burst
      w0 = wlog.size();
      frame_imagem = 1'b1;
      for (int i = 0; i < 3; i++) push(12'h200 + 12'(i), 8'hE0 + 8'(i), acc);
      check("t6_level3", fifo_level, 3'd3);
      reset = 1'b1;
      tick();
      check("t6_level", fifo_level, 3'd0);
      check("t6_we", bus.mem_we, 1'b0);
      check("t6_pvalid", pixel_valid, 1'b0);
      check("t6_ready", bus.wr_ready, 1'b1);
      check("t6_mem_addr", bus.mem_addr, 12'h000);
`ifdef WR_STALL_CNT_EN
      check("t6_stall", stall_count, 16'd0);
`endif
      reset = 1'b0;
      frame_imagem = 1'b0;
      repeat (8) tick();
      check("t6_no_writes", wlog.size(), w0);
      check("t6_ram200", ram[12'h200], 8'h00);
      check("t6_level_after", fifo_level, 3'd0);

      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end
endmodule
